// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs,
// FSM state encodings, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      RTEXEC   = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      IEXEC    = 4'd9,
      IWB      = 4'd10,
      JUMP     = 4'd11,
      TRAP     = 4'd12
   } state_t;

   // These codes are shared with the datapath ALU decoder.
   typedef enum logic [2:0] {
      ALU_ADD     = 3'd0,
      ALU_SUB     = 3'd1,
      ALU_AND     = 3'd2,
      ALU_OR      = 3'd3,
      ALU_NOR     = 3'd4,
      ALU_SLT     = 3'd5,
      ALU_SLL     = 3'd6,
      ALU_INVALID = 3'd7
   } aluop_t;

   localparam logic [1:0] SRCB_RT    = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_op_decoder.sv
// Combinational R-type funct decode into an ALU operation code,
// flagging any funct the ALU does not implement.
module alu_op_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] i_funct,
   output aluop_t     o_aluOp,
   output logic       o_functIllegal
);

   always_comb begin
      o_aluOp        = ALU_INVALID;
      o_functIllegal = 1'b0;
      case (i_funct)
         FN_ADD:  o_aluOp = ALU_ADD;
         FN_SUB:  o_aluOp = ALU_SUB;
         FN_AND:  o_aluOp = ALU_AND;
         FN_OR:   o_aluOp = ALU_OR;
         FN_NOR:  o_aluOp = ALU_NOR;
         FN_SLT:  o_aluOp = ALU_SLT;
         FN_SLL:  o_aluOp = ALU_SLL;
         default: o_functIllegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore decode of the
// state register plus the FETCH ready handshake and the BRANCH zero flag.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
)(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   input  logic       i_memReady,
   output logic       o_pcWrite,
   output logic       o_iOrD,
   output logic       o_memRead,
   output logic       o_memWrite,
   output logic       o_irWrite,
   output logic       o_regDst,
   output logic       o_memToReg,
   output logic       o_regWrite,
   output logic       o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_pcSrc,
   output logic [2:0] o_aluOp,
   output logic       o_illegal,
   output logic [3:0] o_state
);

   state_t     r_state;
   state_t     w_nextState;
   aluop_t     w_rtAluOp;
   logic       w_functIllegal;
   logic       w_pcWrite, w_iOrD, w_memRead, w_memWrite, w_irWrite;
   logic       w_regDst, w_memToReg, w_regWrite, w_aluSrcA, w_illegal;
   logic [1:0] w_aluSrcB, w_pcSrc;
   aluop_t     w_aluOp;

   alu_op_decoder u_aluOpDecoder (
      .i_funct        (i_funct),
      .o_aluOp        (w_rtAluOp),
      .o_functIllegal (w_functIllegal)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= state_t'(RESET_STATE);
      else         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = FETCH;
      w_pcWrite   = 1'b0;
      w_iOrD      = 1'b0;
      w_memRead   = 1'b0;
      w_memWrite  = 1'b0;
      w_irWrite   = 1'b0;
      w_regDst    = 1'b0;
      w_memToReg  = 1'b0;
      w_regWrite  = 1'b0;
      w_aluSrcA   = 1'b0;
      w_aluSrcB   = SRCB_RT;
      w_pcSrc     = PCSRC_ALU;
      w_aluOp     = ALU_ADD;
      w_illegal   = 1'b0;
      case (r_state)
         FETCH: begin
            w_memRead   = 1'b1;
            w_aluSrcB   = SRCB_FOUR;
            w_irWrite   = i_memReady;
            w_pcWrite   = i_memReady;
            w_nextState = i_memReady ? DECODE : FETCH;
         end
         DECODE: begin
            // Precompute the branch target into ALUOut while decoding.
            w_aluSrcB = SRCB_IMMSH;
            case (i_opcode)
               OP_RTYPE:                  w_nextState = RTEXEC;
               OP_LW, OP_SW:              w_nextState = MEMADR;
               OP_BEQ:                    w_nextState = BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI:  w_nextState = IEXEC;
               OP_J:                      w_nextState = JUMP;
               default:                   w_nextState = TRAP;
            endcase
         end
         MEMADR: begin
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = SRCB_IMM;
            w_nextState = (i_opcode == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            w_memRead   = 1'b1;
            w_iOrD      = 1'b1;
            w_nextState = i_memReady ? MEMWB : MEMREAD;
         end
         MEMWRITE: begin
            w_memWrite  = 1'b1;
            w_iOrD      = 1'b1;
            w_nextState = i_memReady ? FETCH : MEMWRITE;
         end
         MEMWB: begin
            w_regWrite = 1'b1;
            w_memToReg = 1'b1;
         end
         RTEXEC: begin
            w_aluSrcA   = 1'b1;
            w_aluOp     = w_rtAluOp;
            w_illegal   = w_functIllegal;
            w_nextState = w_functIllegal ? FETCH : ALUWB;
         end
         ALUWB: begin
            w_regWrite = 1'b1;
            w_regDst   = 1'b1;
         end
         BRANCH: begin
            w_aluSrcA = 1'b1;
            w_aluOp   = ALU_SUB;
            w_pcSrc   = PCSRC_ALUOUT;
            w_pcWrite = i_zero;
         end
         IEXEC: begin
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = SRCB_IMM;
            w_nextState = IWB;
            case (i_opcode)
               OP_ANDI: w_aluOp = ALU_AND;
               OP_ORI:  w_aluOp = ALU_OR;
               default: w_aluOp = ALU_ADD;
            endcase
         end
         IWB:  w_regWrite = 1'b1;
         JUMP: begin
            w_pcSrc   = PCSRC_JUMP;
            w_pcWrite = 1'b1;
         end
         TRAP:    w_illegal = 1'b1;
         default: w_nextState = FETCH;
      endcase
   end

   // Reset suppresses every strobe so an abandoned access cannot write.
   assign o_pcWrite  = w_pcWrite  & ~i_reset;
   assign o_iOrD     = w_iOrD     & ~i_reset;
   assign o_memRead  = w_memRead  & ~i_reset;
   assign o_memWrite = w_memWrite & ~i_reset;
   assign o_irWrite  = w_irWrite  & ~i_reset;
   assign o_regDst   = w_regDst   & ~i_reset;
   assign o_memToReg = w_memToReg & ~i_reset;
   assign o_regWrite = w_regWrite & ~i_reset;
   assign o_aluSrcA  = w_aluSrcA  & ~i_reset;
   assign o_illegal  = w_illegal  & ~i_reset;
   assign o_aluSrcB  = i_reset ? 2'd0 : w_aluSrcB;
   assign o_pcSrc    = i_reset ? 2'd0 : w_pcSrc;
   assign o_aluOp    = i_reset ? 3'd0 : w_aluOp;
   assign o_state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS controller; each step pushes its
// expected control word to a scoreboard that is popped and checked mid-cycle.
module tb_mips_multicycle_ctrl;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       memReady;
   logic       pcWrite, iOrD, memRead, memWrite, irWrite;
   logic       regDst, memToReg, regWrite, aluSrcA, illegal;
   logic [1:0] aluSrcB, pcSrc;
   logic [2:0] aluOp;
   logic [3:0] state;

   typedef struct {
      string       tag;
      logic [20:0] exp;
   } sbEntry_t;

   sbEntry_t scoreboard[$];
   int       checkCount = 0;
   int       passCount  = 0;

   mips_multicycle_ctrl dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_opcode   (opcode),
      .i_funct    (funct),
      .i_zero     (zero),
      .i_memReady (memReady),
      .o_pcWrite  (pcWrite),
      .o_iOrD     (iOrD),
      .o_memRead  (memRead),
      .o_memWrite (memWrite),
      .o_irWrite  (irWrite),
      .o_regDst   (regDst),
      .o_memToReg (memToReg),
      .o_regWrite (regWrite),
      .o_aluSrcA  (aluSrcA),
      .o_aluSrcB  (aluSrcB),
      .o_pcSrc    (pcSrc),
      .o_aluOp    (aluOp),
      .o_illegal  (illegal),
      .o_state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Field order: state, pcWrite, iOrD, memRead, memWrite, irWrite, regDst,
   // memToReg, regWrite, aluSrcA, aluSrcB, pcSrc, aluOp, illegal.
   function automatic logic [20:0] mk(input int st, input bit pw, input bit iod,
                                      input bit mr, input bit mw, input bit irw,
                                      input bit rd, input bit m2r, input bit rw,
                                      input bit sa, input int sb, input int ps,
                                      input int op, input bit ill);
      logic [3:0] s4;
      logic [1:0] sb2, ps2;
      logic [2:0] op3;
      s4  = st[3:0];
      sb2 = sb[1:0];
      ps2 = ps[1:0];
      op3 = op[2:0];
      return {s4, pw, iod, mr, mw, irw, rd, m2r, rw, sa, sb2, ps2, op3, ill};
   endfunction

   // Drive one cycle of inputs and record what the controller must show.
   task automatic applyStimulus(input string tag, input bit rst, input logic [5:0] op,
                                input logic [5:0] fn, input bit z, input bit rdy,
                                input logic [20:0] exp);
      sbEntry_t e;
      reset    = rst;
      opcode   = op;
      funct    = fn;
      zero     = z;
      memReady = rdy;
      e.tag    = tag;
      e.exp    = exp;
      scoreboard.push_back(e);
   endtask

   // Sample mid-cycle, compare against the oldest expectation, then advance.
   task automatic checkOutput();
      sbEntry_t    e;
      logic [20:0] obs;
      @(negedge clk);
      obs = {state, pcWrite, iOrD, memRead, memWrite, irWrite, regDst, memToReg,
             regWrite, aluSrcA, aluSrcB, pcSrc, aluOp, illegal};
      checkCount++;
      if (scoreboard.size() == 0) begin
         $error("[TB] FAIL scoreboard_empty observed=%h required=entry", obs);
      end else begin
         e = scoreboard.pop_front();
         assert (obs === e.exp) passCount++;
         else $error("[TB] FAIL %s observed=%h required=%h (state %0d vs %0d)",
                     e.tag, obs, e.exp, obs[20:17], e.exp[20:17]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input bit rst, input logic [5:0] op,
                       input logic [5:0] fn, input bit z, input bit rdy,
                       input logic [20:0] exp);
      applyStimulus(tag, rst, op, fn, z, rdy, exp);
      checkOutput();
   endtask

   logic [20:0] eFetch, eFetchStall, eDecode, eMemAdr, eMemRead, eMemWb;
   logic [20:0] eMemWrite, eAluWb, eIwb, eIdle;
   logic [5:0]  rtFuncts[7];
   logic [5:0]  iOps[3];
   int          iAluOps[3];

   initial begin
      eIdle       = mk(0, 0,0,0,0,0,0,0,0,0, 0,0,0,0);
      eFetch      = mk(0, 1,0,1,0,1,0,0,0,0, 1,0,0,0);
      eFetchStall = mk(0, 0,0,1,0,0,0,0,0,0, 1,0,0,0);
      eDecode     = mk(1, 0,0,0,0,0,0,0,0,0, 3,0,0,0);
      eMemAdr     = mk(2, 0,0,0,0,0,0,0,0,1, 2,0,0,0);
      eMemRead    = mk(3, 0,1,1,0,0,0,0,0,0, 0,0,0,0);
      eMemWb      = mk(4, 0,0,0,0,0,0,1,1,0, 0,0,0,0);
      eMemWrite   = mk(5, 0,1,0,1,0,0,0,0,0, 0,0,0,0);
      eAluWb      = mk(7, 0,0,0,0,0,1,0,1,0, 0,0,0,0);
      eIwb        = mk(10,0,0,0,0,0,0,0,1,0, 0,0,0,0);
      rtFuncts    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b100111, 6'b101010, 6'b000000};
      iOps        = '{6'b001000, 6'b001100, 6'b001101};
      iAluOps     = '{0, 2, 3};

      reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; memReady = 1'b0;
      @(posedge clk);
      #1;
      step("reset_idle", 1, 6'b000000, 6'b0, 0, 1, eIdle);

      step("fetch_stall", 0, 6'b100011, 6'b0, 0, 0, eFetchStall);
      step("lw_fetch",    0, 6'b100011, 6'b0, 0, 1, eFetch);
      step("lw_decode",   0, 6'b100011, 6'b0, 0, 1, eDecode);
      step("lw_memadr",   0, 6'b100011, 6'b0, 0, 1, eMemAdr);
      step("lw_memread",  0, 6'b100011, 6'b0, 0, 1, eMemRead);
      step("lw_memwb",    0, 6'b100011, 6'b0, 0, 1, eMemWb);

      step("sw_fetch",    0, 6'b101011, 6'b0, 0, 1, eFetch);
      step("sw_decode",   0, 6'b101011, 6'b0, 0, 1, eDecode);
      step("sw_memadr",   0, 6'b101011, 6'b0, 0, 1, eMemAdr);
      for (int i = 0; i < 3; i++)
         step("sw_stall", 0, 6'b101011, 6'b0, 0, 0, eMemWrite);
      step("sw_memwrite", 0, 6'b101011, 6'b0, 0, 1, eMemWrite);

      for (int k = 0; k < 7; k++) begin
         step("rt_fetch",  0, 6'b000000, rtFuncts[k], 0, 1, eFetch);
         step("rt_decode", 0, 6'b000000, rtFuncts[k], 0, 1, eDecode);
         step("rt_exec",   0, 6'b000000, rtFuncts[k], 0, 1,
              mk(6, 0,0,0,0,0,0,0,0,1, 0,0,k,0));
         step("rt_aluwb",  0, 6'b000000, rtFuncts[k], 0, 1, eAluWb);
      end
      step("rtbad_fetch",  0, 6'b000000, 6'b111111, 0, 1, eFetch);
      step("rtbad_decode", 0, 6'b000000, 6'b111111, 0, 1, eDecode);
      step("rtbad_exec",   0, 6'b000000, 6'b111111, 0, 1,
           mk(6, 0,0,0,0,0,0,0,0,1, 0,0,7,1));

      step("beqT_fetch",  0, 6'b000100, 6'b0, 1, 1, eFetch);
      step("beqT_decode", 0, 6'b000100, 6'b0, 1, 1, eDecode);
      step("beqT_branch", 0, 6'b000100, 6'b0, 1, 1, mk(8, 1,0,0,0,0,0,0,0,1, 0,1,1,0));
      step("beqN_fetch",  0, 6'b000100, 6'b0, 0, 1, eFetch);
      step("beqN_decode", 0, 6'b000100, 6'b0, 0, 1, eDecode);
      step("beqN_branch", 0, 6'b000100, 6'b0, 0, 1, mk(8, 0,0,0,0,0,0,0,0,1, 0,1,1,0));

      for (int k = 0; k < 3; k++) begin
         step("imm_fetch",  0, iOps[k], 6'b0, 0, 1, eFetch);
         step("imm_decode", 0, iOps[k], 6'b0, 0, 1, eDecode);
         step("imm_exec",   0, iOps[k], 6'b0, 0, 1,
              mk(9, 0,0,0,0,0,0,0,0,1, 2,0,iAluOps[k],0));
         step("imm_wb",     0, iOps[k], 6'b0, 0, 1, eIwb);
      end

      step("j_fetch",  0, 6'b000010, 6'b0, 0, 1, eFetch);
      step("j_decode", 0, 6'b000010, 6'b0, 0, 1, eDecode);
      step("j_jump",   0, 6'b000010, 6'b0, 0, 1, mk(11, 1,0,0,0,0,0,0,0,0, 0,2,0,0));

      step("trap_fetch",  0, 6'b111111, 6'b0, 0, 1, eFetch);
      step("trap_decode", 0, 6'b111111, 6'b0, 0, 1, eDecode);
      step("trap_trap",   0, 6'b111111, 6'b0, 0, 1, mk(12, 0,0,0,0,0,0,0,0,0, 0,0,0,1));

      step("rst_fetch",   0, 6'b100011, 6'b0, 0, 1, eFetch);
      step("rst_decode",  0, 6'b100011, 6'b0, 0, 1, eDecode);
      step("rst_memadr",  0, 6'b100011, 6'b0, 0, 1, eMemAdr);
      step("rst_memread", 0, 6'b100011, 6'b0, 0, 0, eMemRead);
      step("rst_during",  1, 6'b100011, 6'b0, 0, 1, mk(3, 0,0,0,0,0,0,0,0,0, 0,0,0,0));
      step("rst_after",   0, 6'b100011, 6'b0, 0, 1, eFetch);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Decodes opcode and funct into a per-state control word for the datapath.
- Drives the 3-bit ALU operation code and ALU operand selects, and consumes the ALU Zero flag for beq.
- Sits between the instruction register and the datapath. Memory accesses wait on a ready handshake.

Parameters:
- RESET_STATE, 0, state entered on reset (FETCH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU Zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  PC load enable (includes beq taken)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
- alu_op  out  3  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt, 6 sll, 7 invalid
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- state  out  4  current state, for debug

Behaviour:
- Reset handling:
  - reset high at a clock edge: state <= FETCH.
  - While reset is high, every output except state is forced to 0. This applies mid-instruction too: any in-flight access is abandoned and no partial write is allowed.
- Output timing:
  - Outputs are combinational decodes of the state register (Moore).
  - Exceptions: pc_write in BRANCH equals zero; ir_write and pc_write in FETCH equal mem_ready.
  - Any strobe not listed for a state is 0; alu_op defaults to 0.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, RTEXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, TRAP=12.
- Per-state outputs and transitions:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0; ir_write=pc_write=mem_ready. Stay while mem_ready=0, else go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
    - 000000 -> RTEXEC
    - 100011 (lw), 101011 (sw) -> MEMADR
    - 000100 -> BRANCH
    - 001000 (addi), 001100 (andi), 001101 (ori) -> IEXEC
    - 000010 -> JUMP
    - any other opcode -> TRAP
  - MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEMWB.
  - MEMWRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
  - RTEXEC: alu_src_a=1, alu_src_b=0, alu_op from funct -> ALUWB.
    - funct mapping: 100000 -> 0, 100010 -> 1, 100100 -> 2, 100101 -> 3, 100111 -> 4, 101010 -> 5, 000000 -> 6.
    - Any other funct: alu_op=7, illegal=1, and go to FETCH without write-back.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_write=zero -> FETCH.
  - IEXEC: alu_src_a=1, alu_src_b=2; alu_op = 0 (addi), 2 (andi), 3 (ori) -> IWB.
  - IWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - JUMP: pc_src=2, pc_write=1 -> FETCH.
  - TRAP: illegal=1, no strobes -> FETCH.
- Opcode and funct timing: both are sampled from the IR, which is stable from DECODE onward. The FSM does not re-register them.
- Zero timing: zero is assumed valid within the BRANCH cycle. The datapath ALU must settle before the clock edge.
- Cycle counts with mem_ready=1 throughout:
  - lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3.
- Encoding safety: any unused state encoding (13..15) -> FETCH on the next clock, all outputs 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - state encodings
  - ALU op codes 0..7
  - alu_src_b and pc_src encodings
- The ALU codes must be the same constants the datapath ALU decodes.
- Sub-module alu_op_decoder: combinational funct -> {alu_op, funct_illegal}. It is reused by RTEXEC.

Test Plan:
- Reset mid-lw: reset for 1 cycle while in MEMREAD -> next state FETCH; reg_write, mem_read and mem_write are 0 during reset.
- lw, mem_ready=1: opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB with mem_to_reg=1; 5 cycles total.
- sw with stall: opcode=101011, mem_ready low 3 cycles in MEMWRITE -> mem_write held for 4 cycles, then FETCH; reg_write never 1.
- R-type sweep: each funct {100000,100010,100100,100101,100111,101010,000000} -> alu_op 0..6 in RTEXEC, ALUWB has reg_dst=1. funct=111111 -> alu_op=7, illegal pulse, no reg_write.
- beq: zero=1 -> pc_write=1, pc_src=1 in BRANCH; zero=0 -> pc_write=0; alu_op=1 in both cases.
- Illegal opcode 111111 -> DECODE, then TRAP with illegal=1 for exactly 1 cycle, then FETCH. Also j (000010): JUMP has pc_src=2, pc_write=1.
